// File: rtl/sr04_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : sr04_scheduler
//  Description : Periodic / single-burst trigger scheduler for an SR04 ranging
//                controller with timeout supervision and sample averaging.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr04_scheduler #(
  parameter int PERIOD_US  = 60000,
  parameter int TIMEOUT_US = 30000,
  parameter int AVG_LOG2   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1us,
  input  logic       enable,
  input  logic       single,
  input  logic [8:0] dist_in,
  input  logic       dist_done,
  output logic       sr04_start,
  output logic [8:0] dist_avg,
  output logic       dist_valid,
  output logic       timeout,
  output logic [7:0] timeout_cnt,
  output logic       busy
);

  localparam int c_US_W  = $clog2(PERIOD_US + 1);
  localparam int c_ACC_W = 9 + AVG_LOG2;
  localparam int c_CNT_W = AVG_LOG2 + 1;

  localparam logic [c_CNT_W-1:0] c_LAST_SAMPLE = c_CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [c_US_W-1:0]  c_TO_LAST     = c_US_W'(TIMEOUT_US - 1);
  localparam logic [c_US_W-1:0]  c_PER_LAST    = c_US_W'(PERIOD_US - 1);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_FIRE    = 2'd1;
  localparam logic [1:0] c_MEASURE = 2'd2;
  localparam logic [1:0] c_GAP     = 2'd3;

  logic [1:0]         r_state;
  logic [c_US_W-1:0]  r_us_cnt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_ACC_W-1:0] r_acc;
  logic               r_burst;
  logic               r_start;
  logic [8:0]         r_avg;
  logic               r_valid;
  logic               r_timeout;
  logic [7:0]         r_tcnt;
  logic               r_busy;

  logic [1:0]         w_state_next;
  logic [c_US_W-1:0]  w_us_cnt_d;
  logic [c_CNT_W-1:0] w_cnt_d;
  logic [c_ACC_W-1:0] w_acc_d;
  logic               w_burst_d;
  logic               w_start_d;
  logic [8:0]         w_avg_d;
  logic               w_valid_d;
  logic               w_timeout_d;
  logic [7:0]         w_tcnt_d;
  logic               w_busy_d;

  logic               w_run;
  logic               w_accept;
  logic               w_tmo;
  logic               w_period_end;
  logic               w_last;
  logic [c_ACC_W-1:0] w_sum;

  assign w_run        = enable | r_burst;
  assign w_accept     = (r_state == c_MEASURE) && dist_done;
  // A result arriving on the expiry tick still counts as a valid sample.
  assign w_tmo        = (r_state == c_MEASURE) && tick_1us && (r_us_cnt == c_TO_LAST) && !dist_done;
  assign w_period_end = (r_state == c_GAP) && tick_1us && (r_us_cnt == c_PER_LAST);
  assign w_last       = (r_cnt == c_LAST_SAMPLE);
  assign w_sum        = r_acc + c_ACC_W'(dist_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_us_cnt  <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_burst   <= 1'b0;
      r_start   <= 1'b0;
      r_avg     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_tcnt    <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_us_cnt  <= w_us_cnt_d;
      r_cnt     <= w_cnt_d;
      r_acc     <= w_acc_d;
      r_burst   <= w_burst_d;
      r_start   <= w_start_d;
      r_avg     <= w_avg_d;
      r_valid   <= w_valid_d;
      r_timeout <= w_timeout_d;
      r_tcnt    <= w_tcnt_d;
      r_busy    <= w_busy_d;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:    if (enable || single) w_state_next = c_FIRE;
      c_FIRE:    w_state_next = c_MEASURE;
      c_MEASURE: if (w_accept || w_tmo) w_state_next = c_GAP;
      c_GAP:     if (w_period_end) w_state_next = w_run ? c_FIRE : c_IDLE;
      default:   w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_us_cnt_d  = r_us_cnt;
    w_cnt_d     = r_cnt;
    w_acc_d     = r_acc;
    w_burst_d   = r_burst;
    w_avg_d     = r_avg;
    w_tcnt_d    = r_tcnt;
    w_valid_d   = 1'b0;
    w_timeout_d = 1'b0;
    w_start_d   = (w_state_next == c_FIRE);
    w_busy_d    = (w_state_next != c_IDLE);
    case (r_state)
      c_IDLE: begin
        w_us_cnt_d = '0;
        w_cnt_d    = '0;
        w_acc_d    = '0;
        if (single) w_burst_d = 1'b1;
      end
      c_FIRE: w_us_cnt_d = '0;
      c_MEASURE: begin
        if (tick_1us) w_us_cnt_d = r_us_cnt + c_US_W'(1);
        if (w_accept) begin
          if (w_last) begin
            w_avg_d   = w_sum[c_ACC_W-1:AVG_LOG2];
            w_valid_d = 1'b1;
            w_acc_d   = '0;
            w_cnt_d   = '0;
            w_burst_d = 1'b0;
          end else begin
            w_acc_d = w_sum;
            w_cnt_d = r_cnt + c_CNT_W'(1);
          end
        end else if (w_tmo) begin
          w_timeout_d = 1'b1;
          if (r_tcnt != 8'hFF) w_tcnt_d = r_tcnt + 8'd1;
        end
      end
      c_GAP: if (tick_1us) w_us_cnt_d = r_us_cnt + c_US_W'(1);
      default: w_us_cnt_d = '0;
    endcase
  end

  assign sr04_start  = r_start;
  assign dist_avg    = r_avg;
  assign dist_valid  = r_valid;
  assign timeout     = r_timeout;
  assign timeout_cnt = r_tcnt;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sr04_scheduler.sv
`default_nettype none
// Testbench for sr04_scheduler: directed vector table, randomized measurements
// scored against a sample-queue model, timeout saturation and reset corners.
module tb_sr04_scheduler;
  localparam int PERIOD = 100;
  localparam int TMO    = 50;
  localparam int L      = 2;
  localparam int N      = 4;

  logic       clk = 1'b0;
  logic       rst, tick_1us, enable, single, dist_done;
  logic [8:0] dist_in;
  logic       sr04_start, dist_valid, timeout, busy;
  logic [8:0] dist_avg;
  logic [7:0] timeout_cnt;

  always #5 clk = ~clk;

  sr04_scheduler #(.PERIOD_US(PERIOD), .TIMEOUT_US(TMO), .AVG_LOG2(L)) dut (
    .clk(clk), .rst(rst), .tick_1us(tick_1us), .enable(enable), .single(single),
    .dist_in(dist_in), .dist_done(dist_done), .sr04_start(sr04_start),
    .dist_avg(dist_avg), .dist_valid(dist_valid), .timeout(timeout),
    .timeout_cnt(timeout_cnt), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int tick_div = 2;
  int tick_ph  = 0;

  // reference model state
  int samples[$];
  bit burst_m;
  int exp_tcnt;
  int exp_avg;

  typedef struct {
    int kick;       // 0: continue, 1: single, 2: enable
    int d;          // counted tick on which the result arrives
    int off;        // 1: result arrives one cycle after that tick
    int din;
    bit drop;       // release enable once this measurement resolves
    bit exp_to;
    bit exp_valid;
    int exp_avg;
    bit exp_idle;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tick_1us = (tick_ph == 0);
    tick_ph  = (tick_ph + 1) % tick_div;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, sr04_start, 0);
    chk({tag, "_avg"}, dist_avg, 0);
    chk({tag, "_valid"}, dist_valid, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_tcnt"}, timeout_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic kick(input bit use_single);
    enable    = !use_single;
    single    = use_single;
    dist_done = 1'b0;
    if (use_single) burst_m = 1'b1;
    samples.delete();
    step();
    single = 1'b0;
    chk("start_on_kick", sr04_start, 1);
    chk("busy_on_kick", busy, 1);
  endtask

  // Runs one measurement period from the FIRE cycle to the next FIRE or IDLE.
  task automatic measure(input int d, input int off, input logic [8:0] din, input bit drop,
                         input bit rand_single, output bit saw_to, output bit saw_valid,
                         output int avg_seen, output bit went_idle);
    int cnt = 0;
    bit measuring = 1'b1;
    bit pending = 1'b0;
    bit fin = 1'b0;
    bit ev, et, run_m, dd;
    saw_to = 0; saw_valid = 0; avg_seen = -1; went_idle = 0; run_m = 1'b1;
    dist_done = 1'b0;
    single    = 1'b0;
    step();
    chk("start_one_cycle", sr04_start, 0);
    chk("busy_measure", busy, 1);
    while (!fin) begin
      if (tick_1us) cnt++;
      dd        = pending || (tick_1us && cnt == d && off == 0);
      pending   = tick_1us && cnt == d && off == 1;
      dist_done = dd;
      dist_in   = dd ? din : 9'($urandom_range(0, 511));
      single    = rand_single && ($urandom_range(0, 7) == 0);
      ev = 1'b0;
      et = 1'b0;
      if (measuring && dd) begin
        measuring = 1'b0;
        samples.push_back(int'(din));
        if (samples.size() == N) begin
          int sum = 0;
          foreach (samples[i]) sum += samples[i];
          exp_avg = sum / N;
          ev      = 1'b1;
          burst_m = 1'b0;
          samples.delete();
        end
      end else if (measuring && tick_1us && cnt == TMO) begin
        measuring = 1'b0;
        et        = 1'b1;
        if (exp_tcnt < 255) exp_tcnt++;
      end
      if (drop && !measuring) enable = 1'b0;
      fin   = tick_1us && cnt == PERIOD;
      run_m = enable || burst_m;
      step();
      chk("dist_valid", dist_valid, ev);
      chk("timeout", timeout, et);
      chk("timeout_cnt", timeout_cnt, exp_tcnt);
      chk("dist_avg", dist_avg, exp_avg);
      chk("sr04_start", sr04_start, fin && run_m);
      chk("busy", busy, !fin || run_m);
      if (dist_valid) begin
        saw_valid = 1'b1;
        avg_seen  = dist_avg;
      end
      if (timeout) saw_to = 1'b1;
    end
    dist_done = 1'b0;
    single    = 1'b0;
    went_idle = !run_m;
    if (went_idle) samples.delete();
  endtask

  initial begin
    bit sto, sval, sidle;
    int savg;
    rst = 1'b1; enable = 1'b0; single = 1'b0; dist_done = 1'b0; dist_in = '0; tick_1us = 1'b0;
    burst_m = 1'b0; exp_tcnt = 0; exp_avg = 0;

    //          kick  d  off  din drop to val avg idle
    vecs[0]  = '{1,  10, 0, 100, 0, 0, 0,   0, 0};
    vecs[1]  = '{0,  20, 1, 102, 0, 0, 0,   0, 0};
    vecs[2]  = '{0,  50, 0, 104, 0, 0, 0,   0, 0};
    vecs[3]  = '{0,   5, 0, 106, 0, 0, 1, 103, 1};
    vecs[4]  = '{2,  55, 0,   0, 0, 1, 0,   0, 0};
    vecs[5]  = '{0,  50, 1,   7, 0, 1, 0,   0, 0};
    vecs[6]  = '{0,  12, 0, 511, 0, 0, 0,   0, 0};
    vecs[7]  = '{0,  49, 1, 511, 0, 0, 0,   0, 0};
    vecs[8]  = '{0,   1, 0, 511, 0, 0, 0,   0, 0};
    vecs[9]  = '{0,  50, 0, 511, 0, 0, 1, 511, 0};
    vecs[10] = '{0,  30, 0, 200, 0, 0, 0,   0, 0};
    vecs[11] = '{0,  40, 1, 300, 1, 0, 0,   0, 1};

    step();
    step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();
    chk("idle_after_reset_busy", busy, 0);
    chk("idle_after_reset_start", sr04_start, 0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].kick != 0) kick(vecs[i].kick == 1);
      measure(vecs[i].d, vecs[i].off, 9'(vecs[i].din), vecs[i].drop, 1'b0, sto, sval, savg, sidle);
      chk($sformatf("vec%0d_timeout", i), sto, vecs[i].exp_to);
      chk($sformatf("vec%0d_valid", i), sval, vecs[i].exp_valid);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_avg", i), savg, vecs[i].exp_avg);
      chk($sformatf("vec%0d_idle", i), sidle, vecs[i].exp_idle);
    end
    chk("avg_held_after_drop", dist_avg, 511);
    chk("tcnt_after_table", timeout_cnt, 2);
    step();
    chk("idle_after_drop", busy, 0);

    // randomized continuous mode, stray single pulses must be ignored
    kick(1'b0);
    for (int i = 0; i < 40; i++)
      measure($urandom_range(1, 60), $urandom_range(0, 1), 9'($urandom_range(0, 511)),
              i == 39, 1'b1, sto, sval, savg, sidle);
    chk("rand_enable_idle", sidle, 1);

    // randomized single burst, persists through timeouts until averaged
    kick(1'b1);
    sidle = 1'b0;
    for (int i = 0; i < 200 && !sidle; i++)
      measure($urandom_range(1, 58), $urandom_range(0, 1), 9'($urandom_range(0, 511)),
              1'b0, 1'b1, sto, sval, savg, sidle);
    chk("rand_burst_idle", sidle, 1);

    // timeout counter saturation, one tick per cycle to keep the run short
    tick_div = 1;
    kick(1'b0);
    begin
      int extra = 0;
      for (int i = 0; i < 300; i++) begin
        bit last;
        last = (exp_tcnt == 255) && (extra == 2);
        if (exp_tcnt == 255) extra++;
        measure(9999, 0, 9'd0, last, 1'b0, sto, sval, savg, sidle);
        if (last) break;
      end
    end
    chk("tcnt_saturated", timeout_cnt, 255);

    // reset in the middle of MEASURE, result arriving right after
    tick_div = 2;
    kick(1'b0);
    step();
    step();
    step();
    chk("busy_before_mid_reset", busy, 1);
    rst    = 1'b1;
    enable = 1'b0;
    step();
    chk_reset_outputs("mid_reset");
    rst       = 1'b0;
    dist_done = 1'b1;
    dist_in   = 9'd300;
    step();
    dist_done = 1'b0;
    chk_reset_outputs("post_reset_done");
    step();
    step();
    chk_reset_outputs("post_reset_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sr04_scheduler.md
SR04_SCHEDULER -- requirements
Module: sr04_scheduler

Interface
REQ-001 Parameter PERIOD_US, default 60000: measurement repetition interval in 1 us ticks, counted from each FIRE; SHALL be greater than TIMEOUT_US.
REQ-002 Parameter TIMEOUT_US, default 30000: maximum wait in 1 us ticks for a result after FIRE.
REQ-003 Parameter AVG_LOG2, default 2: number of samples averaged is 2^AVG_LOG2; legal range 0..4.
REQ-004 clk  input  1  system clock; the block uses only this clock.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 tick_1us  input  1  one-cycle strobe every 1 us.
REQ-007 enable  input  1  level; continuous measurement mode while high.
REQ-008 single  input  1  one-cycle pulse; requests one averaged burst.
REQ-009 dist_in  input  9  distance in cm from the ranging controller; valid when dist_done=1.
REQ-010 dist_done  input  1  one-cycle pulse; a measurement has completed.
REQ-011 sr04_start  output  1  one-cycle pulse; starts one ranging measurement.
REQ-012 dist_avg  output  9  last averaged distance in cm; held between updates.
REQ-013 dist_valid  output  1  one-cycle pulse; dist_avg updated this cycle.
REQ-014 timeout  output  1  one-cycle pulse; the current measurement was abandoned.
REQ-015 timeout_cnt  output  8  saturating count of timeouts since reset.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, FIRE, MEASURE, GAP; all outputs registered.
REQ-018 run = enable OR burst; burst is set by single in IDLE and cleared when dist_valid is issued.
REQ-019 IDLE: on enable=1 or single=1 go to FIRE next cycle; clear us_cnt, sample count and accumulator.
REQ-020 FIRE: lasts exactly 1 cycle; sr04_start=1; us_cnt cleared to 0; go to MEASURE.
REQ-021 MEASURE: us_cnt increments on each tick_1us; on dist_done, accumulate dist_in and increment the sample count, then go to GAP.
REQ-022 On the dist_done that makes the sample count reach 2^AVG_LOG2: dist_avg = accumulator sum >> AVG_LOG2 (truncating), dist_valid=1 in the cycle after dist_done, accumulator and count cleared, burst cleared.
REQ-023 Accumulator width is 9+AVG_LOG2 bits; no overflow is possible.
REQ-024 MEASURE timeout: on a tick_1us with us_cnt == TIMEOUT_US-1 and no dist_done, timeout=1 next cycle, timeout_cnt+1 saturating at 255, sample discarded, go to GAP.
REQ-025 If dist_done and the timeout tick occur in the same cycle, dist_done wins and no timeout is raised.
REQ-026 GAP: us_cnt keeps counting; on a tick with us_cnt == PERIOD_US-1, go to FIRE if run=1, else to IDLE.
REQ-027 dist_done outside MEASURE is ignored; single outside IDLE is ignored.
REQ-028 enable falling mid-sequence: the current measurement completes; partial samples are discarded on return to IDLE unless burst=1.
REQ-029 dist_avg holds its value until the next dist_valid; it is not cleared by IDLE.

Reset
REQ-030 With rst=1 at a clk edge: state=IDLE, sr04_start=0, dist_avg=0, dist_valid=0, timeout=0, timeout_cnt=0, busy=0, burst=0, counters and accumulator=0.
REQ-031 Reset SHALL take effect in any state, including mid-MEASURE, with no output pulse issued afterwards.

Verification (PERIOD_US=100, TIMEOUT_US=50, AVG_LOG2=2)
REQ-032 Stimulus: single pulse; dist_done with dist_in 100, 102, 104, 106. Required response: 4 sr04_start pulses 100 us apart; one dist_valid with dist_avg=103; then IDLE with busy=0.
REQ-033 Stimulus: enable=1 and no dist_done. Required response: timeout pulse 50 us after each FIRE; timeout_cnt increments per period and saturates at 255.
REQ-034 Stimulus: dist_done coincident with the 50th tick. Required response: sample accepted; timeout=0; timeout_cnt unchanged.
REQ-035 Stimulus: enable=1, dist_in=511 for 4 samples. Required response: dist_avg=511 with no overflow; sequence continues with the next FIRE.
REQ-036 Stimulus: enable deasserted after 2 samples. Required response: IDLE after the current GAP; no dist_valid; dist_avg unchanged.
REQ-037 Stimulus: rst asserted mid-MEASURE, with dist_done the next cycle. Required response: all outputs at reset values; dist_done ignored.
